adc_row_sequencer: RTL and testbench

ADC_ROW_SEQUENCER -- requirements
Module: adc_row_sequencer

---
 rtl/adc_pkg.sv | 14 +
 rtl/adc_capture_bank.sv | 40 ++++
 rtl/adc_row_sequencer.sv | 119 +++++++++++
 tb/tb_adc_row_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC row sequencer: FSM state encoding and the
// default ramp counter / code width.
package adc_pkg;

  localparam int ADC_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_READOUT = 2'd3
  } adc_state_t;

endpackage

// File: rtl/adc_capture_bank.sv
// Per-pixel rising-edge detect and code capture for one row of column
// comparators. The first crossing of each pixel latches the ramp count;
// later edges on that pixel are ignored until the bank is cleared.
module adc_capture_bank
  import adc_pkg::*;
#(
  parameter int NUM_PIXELS = 11,
  parameter int CNT_W      = ADC_CNT_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             enable,
  input  logic [NUM_PIXELS-1:0]            comp,
  input  logic [CNT_W-1:0]                 count,
  output logic [NUM_PIXELS-1:0]            captured,
  output logic [NUM_PIXELS-1:0][CNT_W-1:0] codes
);

  logic [NUM_PIXELS-1:0] comp_prev;

  // Clear while the ramp settles so the conversion starts from a clean slate;
  // comp_prev=0 on entry makes an already-high comparator capture code 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      comp_prev <= '0;
      captured  <= '0;
      codes     <= '0;
    end else if (enable) begin
      comp_prev <= comp;
      for (int i = 0; i < NUM_PIXELS; i++) begin
        if (comp[i] && !comp_prev[i] && !captured[i]) begin
          codes[i]    <= count;
          captured[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_row_sequencer.sv
// Single-slope ADC row sequencer: settles the ramp, runs a 2^CNT_W-cycle
// conversion while the capture bank latches per-pixel crossing codes, then
// streams one word per pixel over a valid/ready port.
//
// Readout handshake: out_valid is high in every READOUT cycle and does not
// depend on out_ready. A word transfers on a rising edge where out_valid and
// out_ready are both 1; until then out_pixel/out_code/out_ovf hold steady.
module adc_row_sequencer
  import adc_pkg::*;
#(
  parameter int NUM_PIXELS    = 11,
  parameter int CNT_W         = ADC_CNT_W,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_PIXELS-1:0]         comp,
  output logic                          ramp_rst,
  output logic                          ramp_en,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_PIXELS)-1:0] out_pixel,
  output logic [CNT_W-1:0]              out_code,
  output logic                          out_ovf,
  output logic                          frame_done,
  output adc_state_t                    state
);

  localparam int                PIX_W       = $clog2(NUM_PIXELS);
  localparam logic [PIX_W-1:0]  LAST_PIX    = PIX_W'(NUM_PIXELS - 1);
  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  adc_state_t                     next_state;
  logic [7:0]                     settle_cnt;
  logic [CNT_W-1:0]               cnt;
  logic [PIX_W-1:0]               rd_idx;
  logic [NUM_PIXELS-1:0]          captured;
  logic [NUM_PIXELS-1:0][CNT_W-1:0] codes;
  logic                           last_handshake;

  assign last_handshake = (state == ST_READOUT) && out_ready && (rd_idx == LAST_PIX);

  // State register; reset dominates everything else.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; abort overrides every transition including start.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start)                   next_state = ST_SETTLE;
        ST_SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = ST_CONVERT;
        ST_CONVERT: if (cnt == '1)               next_state = ST_READOUT;
        ST_READOUT: if (last_handshake)          next_state = ST_IDLE;
        default:                                 next_state = ST_IDLE;
      endcase
    end
  end

  // Phase counters restart on every state change so each phase counts from 0.
  always_ff @(posedge clk) begin
    if (reset || (next_state != state)) begin
      settle_cnt <= '0;
      cnt        <= '0;
      rd_idx     <= '0;
    end else begin
      if (state == ST_SETTLE)              settle_cnt <= settle_cnt + 8'd1;
      if (state == ST_CONVERT)             cnt        <= cnt + CNT_W'(1);
      if (state == ST_READOUT && out_ready) rd_idx    <= rd_idx + PIX_W'(1);
    end
  end

  // One-cycle pulse in the first IDLE cycle after the final word is taken.
  always_ff @(posedge clk) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= last_handshake && !abort;
  end

  adc_capture_bank #(
    .NUM_PIXELS (NUM_PIXELS),
    .CNT_W      (CNT_W)
  ) u_capture_bank (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == ST_SETTLE),
    .enable   (state == ST_CONVERT),
    .comp     (comp),
    .count    (cnt),
    .captured (captured),
    .codes    (codes)
  );

  assign ramp_rst = (state == ST_SETTLE);
  assign ramp_en  = (state == ST_CONVERT);
  assign busy     = (state != ST_IDLE);

  // Readout mux; pixels that never crossed report full scale with overflow.
  always_comb begin
    out_valid = 1'b0;
    out_pixel = '0;
    out_code  = '0;
    out_ovf   = 1'b0;
    if (state == ST_READOUT) begin
      out_valid = 1'b1;
      out_pixel = rd_idx;
      out_ovf   = !captured[rd_idx];
      out_code  = captured[rd_idx] ? codes[rd_idx] : '1;
    end
  end

endmodule

// File: tb/tb_adc_row_sequencer.sv
// Self-checking bench for adc_row_sequencer: comparator waveforms are
// described per ramp count, the expected readout words are derived from them
// and queued, and each accepted word is popped and compared.
module tb_adc_row_sequencer;
  import adc_pkg::*;

  localparam int NP     = 11;
  localparam int CW     = 8;
  localparam int SETTLE = 4;
  localparam int STEPS  = 1 << CW;
  localparam int PW     = $clog2(NP);
  localparam int W      = PW + 1 + CW;

  logic              clk = 1'b0;
  logic              reset, start, abort, out_ready;
  logic [NP-1:0]     comp;
  logic              ramp_rst, ramp_en, busy, out_valid, out_ovf, frame_done;
  logic [PW-1:0]     out_pixel;
  logic [CW-1:0]     out_code;
  adc_state_t        state;

  logic [W-1:0]      exp_q[$];
  logic [NP-1:0]     wave[0:STEPS-1];
  int                n_tests = 0;
  int                n_fail  = 0;

  adc_row_sequencer #(
    .NUM_PIXELS    (NP),
    .CNT_W         (CW),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .comp       (comp),
    .ramp_rst   (ramp_rst),
    .ramp_en    (ramp_en),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_code   (out_code),
    .out_ovf    (out_ovf),
    .frame_done (frame_done),
    .state      (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rst"},   ramp_rst,   0);
    check({tag, "_en"},    ramp_en,    0);
    check({tag, "_busy"},  busy,       0);
    check({tag, "_valid"}, out_valid,  0);
    check({tag, "_pix"},   out_pixel,  0);
    check({tag, "_code"},  out_code,   0);
    check({tag, "_ovf"},   out_ovf,    0);
    check({tag, "_done"},  frame_done, 0);
    check({tag, "_state"}, int'(state), int'(ST_IDLE));
  endtask

  // waveform helpers: wave[c][p] is comp[p] during the cycle the ramp reads c
  task automatic clear_wave();
    for (int c = 0; c < STEPS; c++) wave[c] = '0;
  endtask

  task automatic set_level(input int p, input int from, input int to, input bit lvl);
    for (int c = from; c <= to && c < STEPS; c++) wave[c][p] = lvl;
  endtask

  // reference model: first high sample of a pixel is its crossing
  task automatic push_expected();
    int code;
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      code = -1;
      for (int c = STEPS - 1; c >= 0; c--) if (wave[c][p]) code = c;
      if (code < 0) exp_q.push_back({PW'(p), 1'b1, CW'(STEPS - 1)});
      else          exp_q.push_back({PW'(p), 1'b0, CW'(code)});
    end
  endtask

  // driver: one full frame with optional abort, reset, stall and noise
  task automatic run_frame(input int abort_cnt, input int reset_pix, input int hold_pix,
                           input int hold_len, input bit extra_start, input bit noisy,
                           input bit rand_ready);
    int           hs;
    int           hold_left;
    int           budget;
    bit           prev_stall;
    logic [W-1:0] prev_word;
    logic [W-1:0] cur;
    logic [W-1:0] e;
    push_expected();
    tick();
    check("idle_busy", busy, 0);
    start = 1'b1;
    for (int n = 1; n <= SETTLE + STEPS; n++) begin
      tick();
      start = extra_start && (n == 2 || n == 100);
      if (n <= SETTLE) begin
        check("settle_rst", ramp_rst, 1);
        check("settle_en", ramp_en, 0);
        check("settle_busy", busy, 1);
        check("settle_valid", out_valid, 0);
        comp = noisy ? '1 : '0;
      end else begin
        check("conv_en", ramp_en, 1);
        check("conv_rst", ramp_rst, 0);
        check("conv_valid", out_valid, 0);
        comp = wave[n - SETTLE - 1];
        if (n - SETTLE - 1 == abort_cnt) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          start = 1'b0;
          comp  = '0;
          check_all_zero("abort");
          for (int k = 0; k < 20; k++) begin
            tick();
            check("abort_valid", out_valid, 0);
            check("abort_done", frame_done, 0);
            check("abort_busy", busy, 0);
          end
          exp_q.delete();
          return;
        end
      end
    end
    start      = 1'b0;
    hs         = 0;
    hold_left  = hold_len;
    budget     = 0;
    prev_stall = 1'b0;
    prev_word  = '0;
    while (exp_q.size() > 0 && budget < 200) begin
      tick();
      budget++;
      comp = noisy ? NP'($urandom) : '0;
      check("rd_valid", out_valid, 1);
      check("rd_busy", busy, 1);
      check("rd_en", ramp_en, 0);
      check("rd_done", frame_done, 0);
      cur = {out_pixel, out_ovf, out_code};
      if (prev_stall) check("hold_stable", cur, prev_word);
      if (reset_pix >= 0 && hs == reset_pix) begin
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        comp  = '0;
        check_all_zero("rd_reset");
        exp_q.delete();
        return;
      end
      if (hs == hold_pix && hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        out_ready = 1'b1;
      end
      if (out_ready) begin
        e = exp_q.pop_front();
        check("word", cur, e);
        hs++;
      end
      prev_stall = !out_ready;
      prev_word  = cur;
    end
    check("readout_timeout", exp_q.size(), 0);
    tick();
    out_ready = 1'b0;
    comp      = '0;
    check("done_pulse", frame_done, 1);
    check("done_busy", busy, 0);
    check("done_valid", out_valid, 0);
    tick();
    check("done_once", frame_done, 0);
  endtask

  initial begin
    int r;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; comp = '0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    start = 1'b0;

    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_prio", busy, 0);

    // pixel 0 at 0, pixel 3 at 100, rest overflow
    clear_wave();
    set_level(0, 0, STEPS - 1, 1'b1);
    set_level(3, 100, STEPS - 1, 1'b1);
    run_frame(-1, -1, -1, 0, 1'b0, 1'b0, 1'b0);

    // first crossing wins; pixel 7 crosses in the last ramp step
    clear_wave();
    set_level(5, 40, 40, 1'b1);
    set_level(5, 90, STEPS - 1, 1'b1);
    set_level(7, STEPS - 1, STEPS - 1, 1'b1);
    run_frame(-1, -1, -1, 0, 1'b0, 1'b0, 1'b0);

    // all pixels cross together; stall 3 cycles on pixel 2
    clear_wave();
    for (int p = 0; p < NP; p++) set_level(p, 200, STEPS - 1, 1'b1);
    run_frame(-1, -1, 2, 3, 1'b0, 1'b0, 1'b0);

    // abort mid-conversion, then a normal frame with ignored start/comp noise
    clear_wave();
    set_level(1, 10, STEPS - 1, 1'b1);
    run_frame(128, -1, -1, 0, 1'b0, 1'b0, 1'b0);
    clear_wave();
    set_level(2, 77, STEPS - 1, 1'b1);
    set_level(9, 3, 5, 1'b1);
    run_frame(-1, -1, -1, 0, 1'b1, 1'b1, 1'b0);

    // reset while pixel 6 is presented, then a randomized frame
    clear_wave();
    set_level(4, 50, STEPS - 1, 1'b1);
    run_frame(-1, 6, -1, 0, 1'b0, 1'b0, 1'b0);
    clear_wave();
    for (int p = 0; p < NP; p++) begin
      r = $urandom_range(0, 300);
      if (r < STEPS) begin
        set_level(p, r, STEPS - 1, 1'b1);
        if (r < STEPS - 4) set_level(p, r + 1, r + 2, 1'b0);
      end
    end
    run_frame(-1, -1, -1, 0, 1'b1, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
